// File: rtl/spi_master_if.sv
// Bus bundle between the SPI initiator and its host/test side.
//
// Handshake: the host raises start for at least one clk cycle while busy=0;
// the initiator accepts it on that edge, latches tx_data and raises busy.
// start is ignored while busy=1 and is not queued. Completion is a
// one-cycle done pulse, in the same cycle that busy falls and rx_data updates.
// miso is only meaningful while cs is low.
interface spi_master_if #(
  parameter int DATA_W = 128
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              miso;
  logic              sclk;
  logic              mosi;
  logic              cs;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;

  // Initiator side.
  modport master (
    input  start, tx_data, miso,
    output sclk, mosi, cs, busy, done, rx_data
  );

  // Host / slave-model side.
  modport slave (
    output start, tx_data, miso,
    input  sclk, mosi, cs, busy, done, rx_data
  );
endinterface

// File: rtl/spi_master.sv
// Mode-0 SPI initiator: one write frame (DATA_W bits out on mosi, LSB first),
// a chip-select gap, then one read frame (DATA_W bits in from miso, LSB first).
// sclk is derived from clk by a divider that ticks every CLK_DIV cycles.
// DATA_W must be >= 2, CLK_DIV >= 2, GAP_TICKS >= 1.
module spi_master #(
  parameter int DATA_W    = 128,
  parameter int CLK_DIV   = 4,
  parameter int GAP_TICKS = 4
) (
  input  logic        clk,
  input  logic        reset,
  spi_master_if.master bus,
  output logic [1:0]  o_dbg_state
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = $clog2(DATA_W);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_GAP   = 2'd2,
    S_READ  = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_div,   w_div_nxt;
  logic [BIT_W-1:0]  r_bit,   w_bit_nxt;
  logic [GAP_W-1:0]  r_gap,   w_gap_nxt;
  logic              r_sclk,  w_sclk_nxt;
  logic              r_cs,    w_cs_nxt;
  logic              r_mosi,  w_mosi_nxt;
  logic              r_busy,  w_busy_nxt;
  logic              r_done,  w_done_nxt;
  logic [DATA_W-1:0] r_tx,    w_tx_nxt;
  logic [DATA_W-1:0] r_rx,    w_rx_nxt;
  logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;

  logic              w_tick;
  logic              w_last_bit;
  logic [IDX_W-1:0]  w_idx;

  // A tick marks one sclk half-period boundary; the divider only runs
  // outside IDLE and restarts from 0 whenever the state changes (which only
  // happens on a tick, so wrapping on the tick covers that).
  assign w_tick     = (r_state != S_IDLE) && (r_div == DIV_W'(CLK_DIV - 1));
  assign w_last_bit = (r_bit == BIT_W'(DATA_W));
  assign w_idx      = r_bit[IDX_W-1:0];

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    w_state_nxt   = r_state;
    w_div_nxt     = (r_state == S_IDLE || w_tick) ? '0 : r_div + 1'b1;
    w_bit_nxt     = r_bit;
    w_gap_nxt     = r_gap;
    w_sclk_nxt    = r_sclk;
    w_cs_nxt      = r_cs;
    w_mosi_nxt    = r_mosi;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;
    w_rx_data_nxt = r_rx_data;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_tx_nxt    = bus.tx_data;
          w_busy_nxt  = 1'b1;
          w_cs_nxt    = 1'b0;
          w_mosi_nxt  = bus.tx_data[0];
          w_bit_nxt   = '0;
          w_state_nxt = S_WRITE;
        end
      end

      S_WRITE: begin
        if (w_tick) begin
          if (!r_sclk) begin
            // Rising edge: the slave samples the bit currently on mosi.
            w_sclk_nxt = 1'b1;
            w_bit_nxt  = r_bit + 1'b1;
          end else begin
            // Falling edge: present the next bit, or close the frame.
            w_sclk_nxt = 1'b0;
            if (!w_last_bit) begin
              w_mosi_nxt = r_tx[w_idx];
            end else begin
              w_cs_nxt    = 1'b1;
              w_mosi_nxt  = 1'b0;
              w_bit_nxt   = '0;
              w_gap_nxt   = '0;
              w_state_nxt = S_GAP;
            end
          end
        end
      end

      S_GAP: begin
        if (w_tick) begin
          if (r_gap == GAP_W'(GAP_TICKS - 1)) begin
            w_gap_nxt   = '0;
            w_cs_nxt    = 1'b0;
            w_state_nxt = S_READ;
          end else begin
            w_gap_nxt = r_gap + 1'b1;
          end
        end
      end

      S_READ: begin
        if (w_tick) begin
          if (!r_sclk) begin
            // Rising edge: capture miso as it stands at this clk edge.
            w_sclk_nxt      = 1'b1;
            w_rx_nxt[w_idx] = bus.miso;
            w_bit_nxt       = r_bit + 1'b1;
          end else begin
            w_sclk_nxt = 1'b0;
            if (w_last_bit) begin
              w_cs_nxt      = 1'b1;
              w_rx_data_nxt = r_rx;
              w_done_nxt    = 1'b1;
              w_busy_nxt    = 1'b0;
              w_bit_nxt     = '0;
              w_state_nxt   = S_IDLE;
            end
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; reset forces the idle bus immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bit     <= '0;
      r_gap     <= '0;
      r_sclk    <= 1'b0;
      r_cs      <= 1'b1;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_bit     <= w_bit_nxt;
      r_gap     <= w_gap_nxt;
      r_sclk    <= w_sclk_nxt;
      r_cs      <= w_cs_nxt;
      r_mosi    <= w_mosi_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_tx      <= w_tx_nxt;
      r_rx      <= w_rx_nxt;
      r_rx_data <= w_rx_data_nxt;
    end
  end

  assign bus.sclk    = r_sclk;
  assign bus.cs      = r_cs;
  assign bus.mosi    = r_mosi;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rx_data = r_rx_data;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a behavioural SPI slave records every write frame
// and answers each read frame from a response queue; directed and random
// transactions are checked for data, frame shape and done latency.
module tb_spi_master;

  localparam int DW  = 128;
  localparam int DIV = 4;
  localparam int GAP = 4;
  localparam int LAT = (4 * DW + GAP) * DIV;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  spi_master_if #(.DATA_W(DW)) bus ();

  spi_master #(
    .DATA_W   (DW),
    .CLK_DIV  (DIV),
    .GAP_TICKS(GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] exp_q[$];    // expected rx_data per completed transaction
  logic [DW-1:0] resp_q[$];   // slave responses, one per read frame
  logic [DW-1:0] frame_q[$];  // mosi words captured per write frame
  int            nbits_q[$];  // rising edges seen per write frame
  int            gap_q[$];    // cs-high cycles between write and read frames

  // ---------------- behavioural slave / monitor ----------------
  bit            in_read   = 1'b0;
  logic          prev_cs   = 1'b1;
  logic          prev_sclk = 1'b0;
  logic [DW-1:0] cap       = '0;
  logic [DW-1:0] cur_resp  = '0;
  int            cap_n     = 0;
  int            rbit      = 0;
  int            gap_len   = 0;
  int            done_cnt  = 0;
  int            mosi_viol = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        in_read   = 1'b0;
        cap       = '0;
        cap_n     = 0;
        rbit      = 0;
        gap_len   = 0;
        bus.miso  = 1'b0;
        prev_cs   = 1'b1;
        prev_sclk = 1'b0;
      end else begin
        if (prev_cs && !bus.cs) begin
          if (in_read) begin
            gap_q.push_back(gap_len);
            cur_resp = (resp_q.size() > 0) ? resp_q.pop_front() : '0;
            rbit     = 0;
            bus.miso = cur_resp[0];
          end else begin
            cap   = '0;
            cap_n = 0;
          end
        end
        if (!bus.cs && !prev_sclk && bus.sclk) begin
          if (!in_read) begin
            if (cap_n < DW) cap[cap_n] = bus.mosi;
            cap_n++;
          end else begin
            rbit++;
          end
        end
        if (!bus.cs && prev_sclk && !bus.sclk && in_read)
          bus.miso = (rbit < DW) ? cur_resp[rbit] : 1'b0;
        if (!prev_cs && bus.cs) begin
          if (!in_read) begin
            frame_q.push_back(cap);
            nbits_q.push_back(cap_n);
            gap_len = 0;
          end
          in_read = !in_read;
        end
        if (bus.cs && in_read) gap_len++;
        if (bus.cs && bus.mosi) mosi_viol++;
        if (bus.done) done_cnt++;
        prev_cs   = bus.cs;
        prev_sclk = bus.sclk;
      end
    end
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- driver tasks ----------------
  // Wait (bounded) for done; returns the cycle count at the done pulse.
  task automatic wait_done(output int t_done, output bit ok);
    ok     = 1'b0;
    t_done = 0;
    for (int i = 0; i < LAT + 200; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ok     = 1'b1;
        t_done = cyc;
        break;
      end
    end
    chki("done_seen", int'(ok), 1);
  endtask

  // Checks made in the cycle where done is high.
  task automatic at_done();
    logic [DW-1:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    chk ("rx_data", bus.rx_data, exp);
    chk1("done_busy", bus.busy, 1'b0);
    chk1("done_cs", bus.cs, 1'b1);
  endtask

  // Compare the next captured write frame against the word sent.
  task automatic check_frame(input logic [DW-1:0] tx);
    chki("frame_present", int'(frame_q.size() > 0), 1);
    if (frame_q.size() > 0) begin
      chk ("mosi_word", frame_q.pop_front(), tx);
      chki("mosi_bits", nbits_q.pop_front(), DW);
    end
    if (gap_q.size() > 0) chki("cs_gap", gap_q.pop_front(), GAP * DIV);
  endtask

  // One complete transaction with a start pulse.
  task automatic run_txn(input logic [DW-1:0] tx, input logic [DW-1:0] resp);
    int t_acc, t_done;
    bit ok;
    resp_q.push_back(resp);
    exp_q.push_back(resp);
    @(posedge clk); #1;
    bus.tx_data = tx;
    bus.start   = 1'b1;
    t_acc       = cyc + 1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.tx_data = rand_word();
    chk1("accept_busy", bus.busy, 1'b1);
    chk1("accept_cs", bus.cs, 1'b0);
    chk1("accept_mosi0", bus.mosi, tx[0]);
    wait_done(t_done, ok);
    if (ok) begin
      chki("latency", t_done - t_acc, LAT);
      at_done();
      @(negedge clk);
      chk1("done_pulse", bus.done, 1'b0);
    end
    check_frame(tx);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [DW-1:0] tx_a, tx_b, tx_c, tx_x;
    int t_acc, t_d1, t_d2, dc_before;
    bit ok, reached;

    bus.start   = 1'b0;
    bus.tx_data = '0;
    reset       = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_cs", bus.cs, 1'b1);
    chk1("rst_sclk", bus.sclk, 1'b0);
    chk1("rst_mosi", bus.mosi, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chk ("rst_rx", bus.rx_data, '0);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      repeat (10) @(negedge clk);
      chk1("idle_cs", bus.cs, 1'b1);
      chk1("idle_sclk", bus.sclk, 1'b0);
      chk1("idle_busy", bus.busy, 1'b0);
    end

    // Directed write/read patterns.
    run_txn(128'h00112233445566778899AABBCCDDEEFF,
            128'hDEADBEEF_0123456789ABCDEF_CAFEF00D);

    // Busy lockout: extra start pulses at cycles 100 and 1500.
    tx_a = rand_word();
    tx_b = ~tx_a;
    resp_q.push_back(rand_word());
    exp_q.push_back(resp_q[resp_q.size() - 1]);
    dc_before = done_cnt;
    @(posedge clk); #1;
    bus.tx_data = tx_a;
    bus.start   = 1'b1;
    t_acc       = cyc + 1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    bus.tx_data = tx_b;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    repeat (1399) @(posedge clk);
    #1;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    wait_done(t_d1, ok);
    if (ok) begin
      chki("lock_latency", t_d1 - t_acc, LAT);
      at_done();
    end
    check_frame(tx_a);
    repeat (100) @(negedge clk);
    chki("lock_frames", frame_q.size(), 0);
    chki("lock_dones", done_cnt - dc_before, 1);
    chk1("lock_idle_cs", bus.cs, 1'b1);

    // Reset in the middle of the write frame.
    tx_c = rand_word();
    dc_before = done_cnt;
    @(posedge clk); #1;
    bus.tx_data = tx_c;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cap_n >= 40) begin
        reached = 1'b1;
        break;
      end
    end
    chki("mid_reached", int'(reached), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk1("mid_cs", bus.cs, 1'b1);
    chk1("mid_sclk", bus.sclk, 1'b0);
    chk1("mid_mosi", bus.mosi, 1'b0);
    chk1("mid_busy", bus.busy, 1'b0);
    chk ("mid_rx", bus.rx_data, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chki("mid_no_done", done_cnt - dc_before, 0);
    chki("mid_no_frame", frame_q.size(), 0);
    run_txn(rand_word(), rand_word());

    // Randomised transactions.
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      run_txn(rand_word(), rand_word());
    end

    // Back-to-back with start held high.
    tx_x = rand_word();
    resp_q.push_back('1);
    resp_q.push_back(128'h1);
    exp_q.push_back('1);
    exp_q.push_back(128'h1);
    @(posedge clk); #1;
    bus.tx_data = tx_x;
    bus.start   = 1'b1;
    t_acc       = cyc + 1;
    wait_done(t_d1, ok);
    if (ok) begin
      chki("b2b_latency", t_d1 - t_acc, LAT);
      at_done();
      @(negedge clk);
      chk1("b2b_done_pulse", bus.done, 1'b0);
      chk1("b2b_restart", bus.busy, 1'b1);
      wait_done(t_d2, ok);
      bus.start = 1'b0;
      if (ok) begin
        chki("b2b_spacing", t_d2 - t_d1, LAT + 1);
        at_done();
      end
    end
    bus.start = 1'b0;
    check_frame(tx_x);
    check_frame(tx_x);
    repeat (20) @(negedge clk);
    chk1("b2b_stop", bus.busy, 1'b0);
    chki("mosi_low_when_cs_high", mosi_viol, 0);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
